vst_agu: RTL
============

VST_AGU -- requirements
Module: vst_agu

Interface
REQ-001 SHALL have parameter ADDR_W, 32, address width in bits.
REQ-002 SHALL have parameter DATA_W, 64, element width in bits (power of two, >=8).
REQ-003 SHALL have parameter VLEN_W, 8, element-count width.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports cmd_valid input 1 / cmd_ready output 1  vector-store command handshake.
REQ-007 SHALL have port cmd_base  input  ADDR_W  byte address of element 0.
REQ-008 SHALL have port cmd_stride  input  ADDR_W  two's-complement byte stride.
REQ-009 SHALL have port cmd_vlen  input  VLEN_W  element count.
REQ-010 SHALL have ports elem_valid input 1 / elem_ready output 1 / elem_data input DATA_W  store-data stream from the vector register file.
REQ-011 SHALL have ports req_valid output 1 / req_ready input 1  write-request handshake toward stp.
REQ-012 SHALL have ports req_addr output ADDR_W, req_data output DATA_W, req_idx output VLEN_W, req_last output 1  request payload.
REQ-013 SHALL have ports busy output 1 (command in progress) and done output 1 (one-cycle completion pulse).

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DRAIN.
REQ-015 cmd_ready SHALL be 1 only in IDLE.
REQ-016 IDLE + cmd handshake with cmd_vlen>0: latch base/stride/vlen, cur_addr<=cmd_base, count<=0, go RUN.
REQ-017 IDLE + cmd handshake with cmd_vlen==0: stay IDLE, pulse done next cycle, emit no requests.
REQ-018 In RUN, elem_ready SHALL equal (!req_valid || req_ready); elem_ready SHALL be 0 in IDLE and DRAIN.
REQ-019 Element handshake at cycle N SHALL present req_valid=1 at N+1 with req_addr=cur_addr, req_data=elem_data, req_idx=count, req_last=(count==vlen-1).
REQ-020 Each element handshake SHALL update cur_addr<=cur_addr+stride modulo 2^ADDR_W (wrap, no error) and count<=count+1.
REQ-021 While req_valid && !req_ready, all req_* outputs SHALL hold stable.
REQ-022 Request handshake without simultaneous element handshake SHALL clear req_valid next cycle; simultaneous handshakes SHALL load the new request (zero bubble).
REQ-023 Handshake of the last element SHALL move RUN->DRAIN; handshake of the request with req_last=1 SHALL move DRAIN->IDLE and pulse done for exactly one cycle on the following cycle.
REQ-024 busy SHALL be 1 in RUN and DRAIN, 0 in IDLE.
REQ-025 Throughput SHALL be one element per cycle with req_ready held high.

Reset
REQ-026 Reset SHALL force IDLE; req_valid, req_last, done, busy=0; req_addr, req_data, req_idx, count, cur_addr=0.
REQ-027 Reset mid-command SHALL discard the in-flight request and remaining elements; cmd_ready=1 the cycle after reset deasserts.

Configuration
REQ-028 Macro VST_ALIGN_CHK_EN defined: SHALL add output align_err (1 bit), set when a request is loaded with req_addr[log2(DATA_W/8)-1:0]!=0, sticky until the next command handshake or reset; requests still issued unchanged.
REQ-029 Macro VST_ALIGN_CHK_EN undefined: align_err port and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-030 base=0x1000, stride=8, vlen=4, req_ready=1 -> addrs 0x1000,0x1008,0x1010,0x1018, idx 0..3, req_last on idx 3, done one cycle after last handshake.
REQ-031 base=0x100, stride=-16 (0xFFFFFFF0), vlen=3 -> addrs 0x100,0x0F0,0x0E0.
REQ-032 base=0xFFFFFFF8, stride=8, vlen=2 -> addrs 0xFFFFFFF8, 0x00000000 (wrap).
REQ-033 req_ready low for 3 cycles mid-stream -> req_* stable, elem_ready=0, no element lost or duplicated.
REQ-034 vlen=0 -> no req_valid, done pulse, busy stays 0; reset asserted during RUN at idx 2 -> req_valid=0, IDLE, new command accepted.
REQ-035 With VST_ALIGN_CHK_EN, base=0x1004, stride=8 -> align_err=1 from first request until next command accepted.

Source files
------------

// File: rtl/vst_agu_if.sv
// Handshake bundle for the vector-store address generator.
// It carries the command, element-stream and write-request channels.
interface vst_agu_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int VLEN_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_base;
    logic [ADDR_W-1:0] cmd_stride;
    logic [VLEN_W-1:0] cmd_vlen;

    logic              elem_valid;
    logic              elem_ready;
    logic [DATA_W-1:0] elem_data;

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic [VLEN_W-1:0] req_idx;
    logic              req_last;

    // Master sits on the issue/consumer side; slave is the address generator.
    modport master (
        output cmd_valid, cmd_base, cmd_stride, cmd_vlen,
        input  cmd_ready,
        output elem_valid, elem_data,
        input  elem_ready,
        input  req_valid, req_addr, req_data, req_idx, req_last,
        output req_ready
    );

    modport slave (
        input  cmd_valid, cmd_base, cmd_stride, cmd_vlen,
        output cmd_ready,
        input  elem_valid, elem_data,
        output elem_ready,
        output req_valid, req_addr, req_data, req_idx, req_last,
        input  req_ready
    );
endinterface

// File: rtl/vst_agu.sv
// Strided vector-store address generator: one write request per element, one per cycle.
// Optional macro VST_ALIGN_CHK_EN adds a sticky element-misalignment flag (align_err).
module vst_agu #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int VLEN_W = 8
) (
    input  logic     clk,
    input  logic     reset,
    vst_agu_if.slave bus,
    output logic     busy,
    output logic     done
`ifdef VST_ALIGN_CHK_EN
    ,
    output logic     align_err
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state_q,     state_d;
    logic [ADDR_W-1:0] stride_q,    stride_d;
    logic [VLEN_W-1:0] vlen_q,      vlen_d;
    logic [ADDR_W-1:0] cur_addr_q,  cur_addr_d;
    logic [VLEN_W-1:0] count_q,     count_d;
    logic              req_valid_q, req_valid_d;
    logic [ADDR_W-1:0] req_addr_q,  req_addr_d;
    logic [DATA_W-1:0] req_data_q,  req_data_d;
    logic [VLEN_W-1:0] req_idx_q,   req_idx_d;
    logic              req_last_q,  req_last_d;
    logic              done_q,      done_d;

    logic cmd_hs;
    logic elem_rdy;
    logic elem_hs;
    logic req_hs;
    logic is_last;

    assign cmd_hs   = bus.cmd_valid && (state_q == IDLE);
    assign elem_rdy = (state_q == RUN) && (!req_valid_q || bus.req_ready);
    assign elem_hs  = elem_rdy && bus.elem_valid;
    assign req_hs   = req_valid_q && bus.req_ready;
    assign is_last  = (count_q == vlen_q - VLEN_W'(1));

    always_comb begin
        state_d     = state_q;
        stride_d    = stride_q;
        vlen_d      = vlen_q;
        cur_addr_d  = cur_addr_q;
        count_d     = count_q;
        req_valid_d = req_valid_q;
        req_addr_d  = req_addr_q;
        req_data_d  = req_data_q;
        req_idx_d   = req_idx_q;
        req_last_d  = req_last_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_hs) begin
                    if (bus.cmd_vlen != '0) begin
                        stride_d   = bus.cmd_stride;
                        vlen_d     = bus.cmd_vlen;
                        cur_addr_d = bus.cmd_base;
                        count_d    = '0;
                        state_d    = RUN;
                    end else begin
                        // Empty vector: complete immediately without issuing anything.
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (elem_hs) begin
                    // Loading over a draining request gives back-to-back issue.
                    req_valid_d = 1'b1;
                    req_addr_d  = cur_addr_q;
                    req_data_d  = bus.elem_data;
                    req_idx_d   = count_q;
                    req_last_d  = is_last;
                    cur_addr_d  = cur_addr_q + stride_q;
                    count_d     = count_q + VLEN_W'(1);
                    if (is_last) begin
                        state_d = DRAIN;
                    end
                end else if (req_hs) begin
                    req_valid_d = 1'b0;
                end
            end
            DRAIN: begin
                if (req_hs) begin
                    req_valid_d = 1'b0;
                    if (req_last_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            stride_q    <= '0;
            vlen_q      <= '0;
            cur_addr_q  <= '0;
            count_q     <= '0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            req_data_q  <= '0;
            req_idx_q   <= '0;
            req_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            stride_q    <= stride_d;
            vlen_q      <= vlen_d;
            cur_addr_q  <= cur_addr_d;
            count_q     <= count_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            req_data_q  <= req_data_d;
            req_idx_q   <= req_idx_d;
            req_last_q  <= req_last_d;
            done_q      <= done_d;
        end
    end

    assign bus.cmd_ready  = (state_q == IDLE);
    assign bus.elem_ready = elem_rdy;
    assign bus.req_valid  = req_valid_q;
    assign bus.req_addr   = req_addr_q;
    assign bus.req_data   = req_data_q;
    assign bus.req_idx    = req_idx_q;
    assign bus.req_last   = req_last_q;
    assign busy           = (state_q != IDLE);
    assign done           = done_q;

`ifdef VST_ALIGN_CHK_EN
    localparam int ALIGN_LSB = $clog2(DATA_W / 8);
    // Mask form keeps an 8-bit element (no offset bits) legal.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((64'd1 << ALIGN_LSB) - 64'd1);

    logic align_err_q, align_err_d;

    always_comb begin
        align_err_d = align_err_q;
        if (cmd_hs) begin
            align_err_d = 1'b0;
        end else if (elem_hs && ((cur_addr_q & ALIGN_MASK) != '0)) begin
            align_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            align_err_q <= 1'b0;
        end else begin
            align_err_q <= align_err_d;
        end
    end

    assign align_err = align_err_q;
`endif

endmodule
